// File: rtl/lcd_text_buffer.sv
// Character store for a ROWS x COLS text LCD. Writers issue PUTC/SETCUR/CLEAR/NEWLINE
// commands; the LCD controller reads back one character per cycle by index.
module lcd_text_buffer #(
  parameter int          COLS  = 16,
  parameter int          ROWS  = 2,
  parameter int          IDX_W = 5,
  parameter logic [7:0]  FILL  = 8'h20
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       cmd,
  input  logic [7:0]       wr_char,
  input  logic [IDX_W-1:0] cmd_loc,
  input  logic [IDX_W-1:0] lcd_index,
  output logic [7:0]       dout,
  output logic [IDX_W-1:0] cursor,
  output logic             busy,
  output logic             err,
  output logic             state_dbg
);

  localparam int                DEPTH   = ROWS * COLS;
  localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]    DEPTH_W = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

  localparam logic [1:0] CMD_PUTC    = 2'b00;
  localparam logic [1:0] CMD_SETCUR  = 2'b01;
  localparam logic [1:0] CMD_CLEAR   = 2'b10;
  localparam logic [1:0] CMD_NEWLINE = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Handshake: a command transfers on a rising edge where wr_valid && wr_ready;
  // wr_ready is high only in ST_IDLE, and the requester keeps wr_valid and its
  // payload stable until that edge.

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_q, clr_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic             err_d;
  logic [IDX_W-1:0] row_base;
  logic [IDX_W:0]   next_base;
  logic [IDX_W-1:0] nl_target;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [7:0]       mem_wdata;
  logic             rd_ok;

  logic [7:0] mem [0:DEPTH-1];

  // Start of the row holding the cursor, and where NEWLINE sends it.
  always_comb begin
    row_base = '0;
    for (int r = 1; r < ROWS; r++) begin
      if ({1'b0, cursor_q} >= (IDX_W+1)'(r * COLS)) row_base = IDX_W'(r * COLS);
    end
    next_base = {1'b0, row_base} + (IDX_W+1)'(COLS);
    nl_target = (next_base >= DEPTH_W) ? '0 : next_base[IDX_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cursor_d  = cursor_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cursor_q[AW-1:0];
    mem_wdata = wr_char;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q[AW-1:0];
        mem_wdata = FILL;
        if (clr_q == LAST) state_d = ST_IDLE;
        else               clr_d   = clr_q + IDX_W'(1);
      end
      ST_IDLE: begin
        if (wr_valid) begin
          case (cmd)
            CMD_PUTC: begin
              mem_we   = 1'b1;
              cursor_d = (cursor_q == LAST) ? '0 : cursor_q + IDX_W'(1);
            end
            CMD_SETCUR: begin
              if ({1'b0, cmd_loc} < DEPTH_W) cursor_d = cmd_loc;
              else                           err_d    = 1'b1;
            end
            CMD_CLEAR: begin
              cursor_d = '0;
              clr_d    = '0;
              state_d  = ST_CLEAR;
            end
            CMD_NEWLINE: cursor_d = nl_target;
            default: ;
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_CLEAR;
      clr_q    <= '0;
      cursor_q <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      cursor_q <= cursor_d;
      err      <= err_d;
    end
  end

  // Store has no reset; the post-reset sweep initialises it.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Read samples the array before this edge's write lands (read-old-data).
  assign rd_ok = ({1'b0, lcd_index} < DEPTH_W);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) dout <= FILL;
    else          dout <= rd_ok ? mem[lcd_index[AW-1:0]] : FILL;
  end

  assign wr_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign cursor    = cursor_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer (2x16 display, 6-bit index so out-of-range
// locations can be addressed).
module tb_lcd_text_buffer;

  localparam int IW = 6;
  localparam logic [1:0] PUTC = 2'b00, SETCUR = 2'b01, CLR = 2'b10, NEWLINE = 2'b11;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    cmd = 2'b00;
  logic [7:0]    wr_char = 8'h00;
  logic [IW-1:0] cmd_loc = '0;
  logic [IW-1:0] lcd_index = '0;
  logic [7:0]    dout;
  logic [IW-1:0] cursor;
  logic          busy;
  logic          err;
  logic          state_dbg;

  int checks = 0;
  int failures = 0;

  lcd_text_buffer #(.COLS(16), .ROWS(2), .IDX_W(IW), .FILL(8'h20)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .cmd      (cmd),
    .wr_char  (wr_char),
    .cmd_loc  (cmd_loc),
    .lcd_index(lcd_index),
    .dout     (dout),
    .cursor   (cursor),
    .busy     (busy),
    .err      (err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_cmd(input logic [1:0] c, input logic [7:0] ch, input logic [IW-1:0] loc,
                        input int exp_waits, input string tag);
    int waits;
    @(negedge clk);
    cmd = c; wr_char = ch; cmd_loc = loc; wr_valid = 1'b1;
    waits = 0;
    while (!wr_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    check({tag, "_wait"}, waits, exp_waits);
  endtask

  task automatic read_at(input int idx, output logic [7:0] v);
    @(negedge clk);
    lcd_index = IW'(idx);
    @(posedge clk);
    #1;
    v = dout;
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  logic [7:0] v;
  int n;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_ready", wr_ready, 0);
    check("rst_cursor", cursor, 0);
    check("rst_dout", dout, 8'h20);
    check("rst_err", err, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    count_sweep(n);
    check("sweep_len", n, 32);
    check("sweep_ready", wr_ready, 1);
    for (int i = 0; i < 32; i++) begin
      read_at(i, v);
      check($sformatf("blank_%0d", i), v, 8'h20);
    end

    // SETCUR then two PUTCs
    do_cmd(SETCUR, 8'h00, 6'd5, 0, "setcur5");
    check("cursor5", cursor, 5);
    do_cmd(PUTC, 8'h48, 6'd0, 0, "putc_h");
    do_cmd(PUTC, 8'h69, 6'd0, 0, "putc_i");
    check("cursor7", cursor, 7);
    read_at(5, v); check("idx5", v, 8'h48);
    read_at(6, v); check("idx6", v, 8'h69);

    // read and write the same index on the same edge
    @(negedge clk); lcd_index = 6'd7;
    do_cmd(PUTC, 8'h5A, 6'd0, 0, "putc_z");
    check("rdw_old", dout, 8'h20);
    @(posedge clk); #1;
    check("rdw_new", dout, 8'h5A);
    check("cursor8", cursor, 8);

    // wrap at last location
    do_cmd(SETCUR, 8'h00, 6'd31, 0, "setcur31");
    do_cmd(PUTC, 8'h41, 6'd0, 0, "putc_a");
    check("cursor_wrap", cursor, 0);
    read_at(31, v); check("idx31", v, 8'h41);

    // newline
    do_cmd(SETCUR, 8'h00, 6'd20, 0, "setcur20");
    do_cmd(NEWLINE, 8'h00, 6'd0, 0, "nl_last");
    check("nl_from_row1", cursor, 0);
    do_cmd(SETCUR, 8'h00, 6'd3, 0, "setcur3");
    do_cmd(NEWLINE, 8'h00, 6'd0, 0, "nl_row0");
    check("nl_from_3", cursor, 16);
    do_cmd(SETCUR, 8'h00, 6'd15, 0, "setcur15");
    do_cmd(NEWLINE, 8'h00, 6'd0, 0, "nl_col15");
    check("nl_from_15", cursor, 16);
    read_at(5, v); check("nl_store", v, 8'h48);

    // rejected SETCUR
    do_cmd(SETCUR, 8'h00, 6'd9, 0, "setcur9");
    do_cmd(SETCUR, 8'h00, 6'd40, 0, "setcur40");
    check("err_pulse", err, 1);
    check("err_cursor", cursor, 9);
    @(posedge clk); #1;
    check("err_drop", err, 0);
    do_cmd(SETCUR, 8'h00, 6'd32, 0, "setcur32");
    check("err32", err, 1);
    check("err32_cursor", cursor, 9);
    read_at(40, v); check("idx40", v, 8'h20);
    check("err_after", err, 0);

    // CLEAR with a PUTC held through the sweep
    do_cmd(CLR, 8'h00, 6'd0, 0, "clear1");
    check("clr_busy", busy, 1);
    check("clr_cursor", cursor, 0);
    do_cmd(PUTC, 8'h58, 6'd0, 32, "putc_held");
    check("held_cursor", cursor, 1);
    read_at(0, v); check("held_idx0", v, 8'h58);
    read_at(5, v); check("held_idx5", v, 8'h20);

    // reset during a sweep
    do_cmd(SETCUR, 8'h00, 6'd31, 0, "setcur31b");
    do_cmd(PUTC, 8'h41, 6'd0, 0, "putc_a2");
    @(negedge clk); lcd_index = 6'd31;
    do_cmd(CLR, 8'h00, 6'd0, 0, "clear2");
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_uncleared", dout, 8'h41);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 8'h20);
    check("mid_rst_cursor", cursor, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_sweep(n);
    check("resweep_len", n, 32);
    read_at(31, v); check("resweep_idx31", v, 8'h20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 16, characters per display row.
REQ-002 SHALL have parameter ROWS, default 2, display rows; DEPTH = ROWS*COLS.
REQ-003 SHALL have parameter IDX_W, default 5, index width; SHALL satisfy 2^IDX_W >= DEPTH.
REQ-004 SHALL have parameter FILL, default 8'h20, blank character code.
REQ-005 SHALL have port CLOCK_50  input  1  sole clock, rising-edge.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_valid  input  1  command request.
REQ-008 SHALL have port wr_ready  output  1  command accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-009 SHALL have port cmd  input  2  command code: 00 PUTC, 01 SETCUR, 10 CLEAR, 11 NEWLINE.
REQ-010 SHALL have port wr_char  input  8  character for PUTC.
REQ-011 SHALL have port cmd_loc  input  IDX_W  target cursor for SETCUR.
REQ-012 SHALL have port lcd_index  input  IDX_W  read address from LCD_Controller.
REQ-013 SHALL have port dout  output  8  registered character at lcd_index.
REQ-014 SHALL have port cursor  output  IDX_W  current write position.
REQ-015 SHALL have port busy  output  1  high while a clear sweep is in progress.
REQ-016 SHALL have port err  output  1  one-cycle pulse on a rejected SETCUR.

Function
REQ-017 SHALL hold a DEPTH x 8 character store; index = row*COLS + col.
REQ-018 SHALL implement states CLEAR and IDLE; wr_ready SHALL equal (state==IDLE); busy SHALL equal (state==CLEAR).
REQ-019 CLEAR: SHALL write FILL to one location per cycle, ascending from clear counter 0 to DEPTH-1, then enter IDLE on the next edge; duration is exactly DEPTH cycles.
REQ-020 PUTC accepted: SHALL write wr_char at cursor; cursor becomes cursor+1, or 0 when cursor == DEPTH-1.
REQ-021 SETCUR accepted: cmd_loc < DEPTH sets cursor = cmd_loc; cmd_loc >= DEPTH leaves cursor unchanged and SHALL pulse err high for exactly one cycle.
REQ-022 NEWLINE accepted: cursor becomes (row+1)*COLS for the current row, or 0 from the last row; the store SHALL be unchanged.
REQ-023 CLEAR accepted: cursor SHALL reset to 0, clear counter to 0, and state to CLEAR on the same edge.
REQ-024 Commands presented while wr_ready is low SHALL be ignored with no side effects; the requester holds wr_valid.
REQ-025 Read latency SHALL be 1 cycle: dout at edge N+1 reflects lcd_index sampled at edge N.
REQ-026 lcd_index >= DEPTH SHALL return FILL.
REQ-027 A read and a PUTC to the same index on the same edge SHALL return the pre-write value, with the new value visible from the next read.
REQ-028 Reads during CLEAR SHALL return FILL for locations already cleared and the prior contents for locations not yet cleared.
REQ-029 cursor SHALL update on the acceptance edge; err SHALL be registered.

Reset
REQ-030 On reset_n low, asynchronously: cursor=0, dout=FILL, err=0, clear counter=0, state=CLEAR (busy=1, wr_ready=0).
REQ-031 After reset_n deasserts, the block SHALL perform a full DEPTH-cycle clear sweep before accepting commands; store contents need not be reset directly.
REQ-032 Reset asserted mid-sweep or mid-command SHALL abort the operation and restart per REQ-030 and REQ-031.

Verification
REQ-033 Reset release, defaults -> busy=1 for exactly 32 cycles, then wr_ready=1; every lcd_index 0..31 reads 8'h20.
REQ-034 SETCUR 5 then PUTC 'H' (8'h48) and 'i' (8'h69) -> index 5 = 8'h48, index 6 = 8'h69, cursor=7.
REQ-035 SETCUR 31 then PUTC 8'h41 -> index 31 = 8'h41 and cursor wraps to 0; SETCUR 20 then NEWLINE -> cursor=0; SETCUR 3 then NEWLINE -> cursor=16.
REQ-036 SETCUR 40 -> err high for exactly one cycle, cursor unchanged; lcd_index 40 reads 8'h20.
REQ-037 CLEAR, then PUTC held on wr_valid throughout the sweep -> PUTC not accepted until cycle 33, then written at index 0.
REQ-038 reset_n pulsed low at clear cycle 10 -> dout=8'h20 immediately, and a new full 32-cycle sweep follows.
